udp_tx_framer: RTL
==================

// Module: udp_tx_framer
// PURPOSE
//  Downstream of the Avalon-MM UDP send-configuration register block. A one-cycle
//  start pulse launches a frame. The block then emits a byte stream toward the MAC TX
//  interface, in this order:
//  - Ethernet header, IPv4 header and UDP header: 42 bytes.
//  - length_i payload bytes, pulled from the payload byte stream.
//  - Zero padding up to the 60-byte Ethernet minimum (FCS is appended by the MAC).
// PARAMETERS
//  SRC_MAC      48'h020000000001  local MAC address (source field)
//  SRC_IP       32'hAC1B01F0      local IPv4 address (source field)
//  IP_TTL       8'd64             IPv4 time-to-live
//  MAX_PAYLOAD  1472              largest accepted UDP payload length, in bytes
// PORTS
//  clk               in   1   clock; all logic rising-edge
//  reset_n           in   1   asynchronous, active-low reset
//  start_i           in   1   single-cycle send request (udp_sendpacket)
//  length_i          in   16  UDP payload length in bytes
//  checksum_i        in   16  precomputed IPv4 header checksum
//  local_port_i      in   16  UDP source port
//  remote_port_i     in   16  UDP destination port
//  remote_ip_i       in   32  destination IPv4 address
//  remote_mac_lsb_i  in   32  destination MAC [31:0]
//  remote_mac_msb_i  in   32  destination MAC [47:32] on bits [15:0]; bits [31:16] ignored
//  pl_data_i         in   8   payload byte
//  pl_valid_i        in   1   payload byte valid
//  pl_ready_o        out  1   payload byte consumed this cycle when pl_valid_i=1
//  tx_data_o         out  8   frame byte
//  tx_valid_o        out  1   tx_data_o valid
//  tx_ready_i        in   1   sink accepts a byte when tx_valid_o=1 and tx_ready_i=1
//  tx_sop_o          out  1   marks byte 0 of the frame
//  tx_eop_o          out  1   marks the last byte of the frame
//  busy_o            out  1   frame in progress
//  drop_o            out  1   1-cycle pulse: start_i rejected
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; latched fields 0; byte counter 0.
//  Start acceptance
//  - start_i in IDLE with length_i<=MAX_PAYLOAD: latch all *_i config fields.
//  - Next state HDR, counter 0, busy_o=1 from the next cycle.
//  - start_i with length_i>MAX_PAYLOAD: ignored; drop_o pulses the following cycle.
//  - start_i while busy_o=1: ignored; drop_o pulses the following cycle.
//  - Config inputs changing mid-frame have no effect; only latched values are used.
//  HDR, bytes 0..41, all fields MSB first
//  - 0-5 dst MAC; 6-11 SRC_MAC; 12-13 0x0800.
//  - 14 0x45; 15 0x00; 16-17 IP total length = len+28; 18-19 0x0000 (ID).
//  - 20-21 0x4000 (DF); 22 IP_TTL; 23 0x11; 24-25 checksum_i.
//  - 26-29 SRC_IP; 30-33 remote IP.
//  - 34-35 local port; 36-37 remote port; 38-39 UDP length = len+8; 40-41 0x0000.
//  - Length sums are 16-bit; no overflow is possible because len<=MAX_PAYLOAD.
//  - tx_valid_o=1 throughout HDR. Counter advances only on a tx handshake.
//  - tx_sop_o=1 while counter=0.
//  - Byte 41 accepted: next state is PAYLOAD if len>0, PAD if len=0.
//  PAYLOAD (combinational pass-through)
//  - tx_data_o=pl_data_i; tx_valid_o=pl_valid_i; pl_ready_o=tx_ready_i.
//  - pl_ready_o=0 in every other state.
//  - Payload counter counts handshakes. Last payload byte accepted: go to PAD if
//    len<18, else end the frame.
//  PAD
//  - Emits 18-len bytes of 0x00 with tx_valid_o=1.
//  EOP and frame end
//  - tx_eop_o=1 on the final byte: last pad byte, or last payload byte when len>=18.
//  - Frame size = max(60, 42+len) bytes.
//  - EOP accepted: next state IDLE, busy_o=0. A new start_i is accepted on the
//    cycle after that.
//  Flow control and reset
//  - tx_ready_i=0 holds tx_data_o, tx_sop_o and tx_eop_o stable.
//  - reset_n low mid-frame aborts immediately; no EOP is emitted.
// TESTING
//  1. Reset mid-HDR (counter=20) -> tx_valid_o=0, busy_o=0 immediately.
//     After release, start_i is accepted.
//  2. len=4, MAC d4bd_d93049d0, IP ac1b01eb, ports AAAA/FDE2, chk 0BFF, tx_ready=1
//     -> 60 bytes total; bytes 16-17=00 20; 38-39=00 0C; 24-25=0B FF; 46-59=00.
//     EOP on byte 59.
//  3. len=100, random pl_valid and tx_ready stalls -> 142 bytes, no pad,
//     payload in order, EOP on byte 141 only.
//  4. len=0 -> 42 header bytes + 18 zero bytes; pl_ready_o never asserted.
//  5. start_i during busy, then len=1473 in IDLE -> two drop_o pulses;
//     the frame in flight is unchanged.

Source files
------------

// File: rtl/udp_tx_framer.sv
// UDP/IPv4/Ethernet transmit framer: header generation, payload pass-through and
// zero padding to the 60-byte Ethernet minimum, on a valid/ready byte stream.
module udp_tx_framer #(
    parameter logic [47:0] SRC_MAC     = 48'h020000000001,
    parameter logic [31:0] SRC_IP      = 32'hAC1B01F0,
    parameter logic [7:0]  IP_TTL      = 8'd64,
    parameter int          MAX_PAYLOAD = 1472
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic [15:0] length_i,
    input  logic [15:0] checksum_i,
    input  logic [15:0] local_port_i,
    input  logic [15:0] remote_port_i,
    input  logic [31:0] remote_ip_i,
    input  logic [31:0] remote_mac_lsb_i,
    input  logic [31:0] remote_mac_msb_i,
    input  logic [7:0]  pl_data_i,
    input  logic        pl_valid_i,
    output logic        pl_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        tx_sop_o,
    output logic        tx_eop_o,
    output logic        busy_o,
    output logic        drop_o,
    output logic [1:0]  state_o
);

    // Handshakes: a byte moves on tx (and pl) when valid and ready are both high
    // at the rising edge of clk; valid never waits for ready.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        PAD     = 2'd3
    } state_t;

    localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
    localparam logic [15:0] HDR_LAST = 16'd41;
    localparam logic [15:0] MIN_LAST = 16'd59;

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;

    logic [15:0] len_q;
    logic [15:0] chk_q;
    logic [15:0] lport_q;
    logic [15:0] rport_q;
    logic [31:0] rip_q;
    logic [47:0] rmac_q;

    logic        start_ok;
    logic [15:0] ip_len;
    logic [15:0] udp_len;
    logic [15:0] pay_last;
    logic        len_short;
    logic [7:0]  hdr_byte;
    logic        unused_bits;

    assign unused_bits = &{1'b0, remote_mac_msb_i[31:16]};

    assign start_ok  = start_i && (state == IDLE) && (length_i <= MAX_LEN);
    assign ip_len    = len_q + 16'd28;
    assign udp_len   = len_q + 16'd8;
    // cnt is the frame byte index, so the last payload byte sits at 41+len.
    assign pay_last  = len_q + HDR_LAST;
    assign len_short = len_q < 16'd18;

    assign busy_o  = (state != IDLE);
    assign state_o = state;

    always_comb begin
        hdr_byte = 8'h00;
        case (cnt[5:0])
            6'd0:  hdr_byte = rmac_q[47:40];
            6'd1:  hdr_byte = rmac_q[39:32];
            6'd2:  hdr_byte = rmac_q[31:24];
            6'd3:  hdr_byte = rmac_q[23:16];
            6'd4:  hdr_byte = rmac_q[15:8];
            6'd5:  hdr_byte = rmac_q[7:0];
            6'd6:  hdr_byte = SRC_MAC[47:40];
            6'd7:  hdr_byte = SRC_MAC[39:32];
            6'd8:  hdr_byte = SRC_MAC[31:24];
            6'd9:  hdr_byte = SRC_MAC[23:16];
            6'd10: hdr_byte = SRC_MAC[15:8];
            6'd11: hdr_byte = SRC_MAC[7:0];
            6'd12: hdr_byte = 8'h08;
            6'd13: hdr_byte = 8'h00;
            6'd14: hdr_byte = 8'h45;
            6'd15: hdr_byte = 8'h00;
            6'd16: hdr_byte = ip_len[15:8];
            6'd17: hdr_byte = ip_len[7:0];
            6'd18: hdr_byte = 8'h00;
            6'd19: hdr_byte = 8'h00;
            6'd20: hdr_byte = 8'h40;
            6'd21: hdr_byte = 8'h00;
            6'd22: hdr_byte = IP_TTL;
            6'd23: hdr_byte = 8'h11;
            6'd24: hdr_byte = chk_q[15:8];
            6'd25: hdr_byte = chk_q[7:0];
            6'd26: hdr_byte = SRC_IP[31:24];
            6'd27: hdr_byte = SRC_IP[23:16];
            6'd28: hdr_byte = SRC_IP[15:8];
            6'd29: hdr_byte = SRC_IP[7:0];
            6'd30: hdr_byte = rip_q[31:24];
            6'd31: hdr_byte = rip_q[23:16];
            6'd32: hdr_byte = rip_q[15:8];
            6'd33: hdr_byte = rip_q[7:0];
            6'd34: hdr_byte = lport_q[15:8];
            6'd35: hdr_byte = lport_q[7:0];
            6'd36: hdr_byte = rport_q[15:8];
            6'd37: hdr_byte = rport_q[7:0];
            6'd38: hdr_byte = udp_len[15:8];
            6'd39: hdr_byte = udp_len[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        tx_data_o  = 8'h00;
        tx_valid_o = 1'b0;
        tx_sop_o   = 1'b0;
        tx_eop_o   = 1'b0;
        pl_ready_o = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nx = HDR;
                    cnt_nx   = 16'd0;
                end
            end
            HDR: begin
                tx_valid_o = 1'b1;
                tx_data_o  = hdr_byte;
                tx_sop_o   = (cnt == 16'd0);
                if (tx_ready_i) begin
                    cnt_nx = cnt + 16'd1;
                    if (cnt == HDR_LAST)
                        state_nx = (len_q == 16'd0) ? PAD : PAYLOAD;
                end
            end
            PAYLOAD: begin
                tx_data_o  = pl_data_i;
                tx_valid_o = pl_valid_i;
                pl_ready_o = tx_ready_i;
                tx_eop_o   = pl_valid_i && (cnt == pay_last) && !len_short;
                if (pl_valid_i && tx_ready_i) begin
                    cnt_nx = cnt + 16'd1;
                    if (cnt == pay_last) begin
                        state_nx = len_short ? PAD : IDLE;
                        if (!len_short)
                            cnt_nx = 16'd0;
                    end
                end
            end
            PAD: begin
                tx_valid_o = 1'b1;
                tx_eop_o   = (cnt == MIN_LAST);
                if (tx_ready_i) begin
                    cnt_nx = cnt + 16'd1;
                    if (cnt == MIN_LAST) begin
                        state_nx = IDLE;
                        cnt_nx   = 16'd0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            len_q   <= 16'd0;
            chk_q   <= 16'd0;
            lport_q <= 16'd0;
            rport_q <= 16'd0;
            rip_q   <= 32'd0;
            rmac_q  <= 48'd0;
            drop_o  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            // Any start that is not taken (busy or oversize) is reported one cycle later.
            drop_o <= start_i && !start_ok;
            if (start_ok) begin
                len_q   <= length_i;
                chk_q   <= checksum_i;
                lport_q <= local_port_i;
                rport_q <= remote_port_i;
                rip_q   <= remote_ip_i;
                rmac_q  <= {remote_mac_msb_i[15:0], remote_mac_lsb_i};
            end
        end
    end

endmodule
